cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Round-robin arbiter that shares the single cache request port (CACHE::cache_cmd_t command, 64-bit address/data, ca_respcyc/ca_resp_data response) between NREQ requesters, such as instruction fetch and the memory pipeline. It sits between the requesters and the cache. It grants one requester at a time and holds that grant until the cache returns ca_respcyc. It steers the response strobe back to the owner, and includes a watchdog that aborts a transaction the cache never answers.

## Interface
- NREQ, 2: number of requesters, legal range 2..4.
- TIMEOUT, 1024: maximum cycles a grant may wait for ca_respcyc; 0 disables the watchdog.
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_cmd[NREQ]  in  cache_cmd_t  per-requester command; non-IDLE = request; held until that requester's respcyc.
- req_addr[NREQ]  in  64  per-requester address.
- req_data[NREQ]  in  64  per-requester write data.
- req_respcyc[NREQ]  out  1  response strobe, asserted only to the current owner.
- req_resp_data  out  64  ca_resp_data broadcast to all requesters.
- ca_req_cmd  out  cache_cmd_t  command to the cache.
- ca_req_addr  out  64  address to the cache.
- ca_req_data  out  64  write data to the cache.
- ca_respcyc  in  1  cache response strobe.
- ca_resp_data  in  64  cache response data.
- owner  out  $clog2(NREQ)  current or last grant index.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States (ARB_IDLE, ARB_BUSY); registered owner_ff, last_ff, wd_cnt.
- ARB_IDLE:
  - ca_req_cmd=IDLE, ca_req_addr=0, ca_req_data=0.
  - If any req_cmd[i]!=IDLE, pick the first requesting index scanning last_ff+1, last_ff+2, … modulo NREQ.
  - Next state: owner_ff=last_ff=pick, go to ARB_BUSY, wd_cnt=0.
- ARB_BUSY:
  - ca_req_cmd/addr/data are combinational copies of req_*[owner_ff].
  - req_respcyc[owner_ff]=ca_respcyc; all other req_respcyc=0.
  - wd_cnt increments each cycle without ca_respcyc.
- ca_respcyc in ARB_BUSY (back-to-back arbitration):
  - Same cycle, pick among requesters excluding owner_ff (the owner's cmd may still be non-IDLE this cycle).
  - If a pick exists, stay in ARB_BUSY with the new owner and clear wd_cnt; otherwise go to ARB_IDLE.
- Watchdog: TIMEOUT!=0 and wd_cnt==TIMEOUT-1 without ca_respcyc:
  - Pulse timeout_err for one cycle and go to ARB_IDLE.
  - The aborted requester receives no respcyc.
- ca_respcyc in ARB_IDLE (late or spurious response): dropped; no req_respcyc asserted.
- Owner drops req_cmd to IDLE before its response: passed through as-is; no state change (protocol violation, checked by assertion only).
- req_resp_data=ca_resp_data always, not gated.

## Timing
- Reset values: state=ARB_IDLE, last_ff=NREQ-1 (index 0 wins first), owner=NREQ-1, wd_cnt=0, timeout_err=0, all req_respcyc=0, ca_req_cmd=IDLE, ca_req_addr=0, ca_req_data=0.
- Reset is asynchronous: asserting reset_n low mid-transaction forces ca_req_cmd=IDLE immediately, without waiting for a clock edge.
- Request first seen non-IDLE at edge t in ARB_IDLE: ca_req_cmd valid from cycle t+1.
- ca_respcyc at cycle r: req_respcyc[owner] in cycle r, with zero latency; next grantee's command on the cache port from cycle r+1, with no bubble.
- Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1 grants.
- Watchdog: with TIMEOUT=T, timeout_err fires in the T-th BUSY cycle without a response.

## Structure
- New package CacheArbTypes: arb_state_t; function rr_pick(mask, last) returning {valid, index}.
- Sub-module rr_picker (combinational): parameter NREQ; inputs req mask and last index; outputs valid and index. Shared between the IDLE and respcyc pick paths by muxing the mask.
- cache_cmd_t is reused from the existing CACHE package; nothing is redefined.

## Test plan
- Reset then single request: req_cmd[1]=READ, addr 0x1000 at cycle 2 → ca_req_cmd=READ, ca_req_addr=0x1000 from cycle 3; ca_respcyc with data 0xDEADBEEF at cycle 7 → req_respcyc[1]=1 and req_resp_data=0xDEADBEEF in cycle 7; ARB_IDLE at cycle 8.
- Simultaneous: req0=READ and req1=WRITE (data 0x55) both at cycle 2 → req0 granted first; at its respcyc req1's WRITE appears on the port the next cycle; a third round with both requesting grants req0 again.
- Fairness: req0 re-requests every cycle after each response while req1 requests continuously → grants strictly alternate 0,1,0,1 over 8 transactions.
- Watchdog: TIMEOUT=8, req0=FLUSH and the cache never responds → timeout_err pulses in the 8th BUSY cycle and state returns to IDLE; a later ca_respcyc produces no req_respcyc.
- Async reset mid-transaction: drop reset_n between edges while BUSY → ca_req_cmd=IDLE and owner=NREQ-1 before the next edge; after release, a fresh req1 request is granted normally.
- Spurious response: ca_respcyc pulsed in ARB_IDLE → all req_respcyc remain 0; state unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Existing cache request-port types shared by every cache client.
// The arbiter reuses cache_cmd_t from here unchanged.
package CACHE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FLUSH = 2'd3
  } cache_cmd_t;

endpackage

// File: rtl/cache_port_arbiter_pkg.sv
// Types and the round-robin pick helper for cache_port_arbiter.
// The helper is sized for the largest supported requester count (4).
package CacheArbTypes;

  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] index;
  } rr_pick_t;

  // Walk downwards so the candidate closest after 'last' is the one left standing.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] mask,
                                       input logic [IDX_W-1:0]    last,
                                       input int                  nreq);
    rr_pick_t         res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = MAX_NREQ; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = IDX_W'((int'(last) + k) % nreq);
        if (mask[idx]) begin
          res.valid = 1'b1;
          res.index = idx;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req after index last.
module rr_picker
  import CacheArbTypes::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   index
);

  logic [MAX_NREQ-1:0] mask_ext;
  logic [IDX_W-1:0]    last_ext;
  rr_pick_t            pick;

  assign mask_ext = MAX_NREQ'(req);
  assign last_ext = IDX_W'(last);
  assign pick     = rr_pick(mask_ext, last_ext, NREQ);
  assign valid    = pick.valid;
  assign index    = pick.index[IW-1:0];

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin sharing of the single cache request port between NREQ requesters,
// with zero-bubble hand-over on ca_respcyc and a watchdog for unanswered grants.
//
// state    | meaning
// ARB_IDLE | no grant; cache port driven IDLE/0
// ARB_BUSY | owner_ff drives the cache port, waiting for ca_respcyc
module cache_port_arbiter
  import CACHE::*;
  import CacheArbTypes::*;
#(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = 1024,
  localparam int IW      = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  cache_cmd_t       req_cmd     [NREQ],
  input  logic [63:0]      req_addr    [NREQ],
  input  logic [63:0]      req_data    [NREQ],
  output logic [NREQ-1:0]  req_respcyc,
  output logic [63:0]      req_resp_data,
  output cache_cmd_t       ca_req_cmd,
  output logic [63:0]      ca_req_addr,
  output logic [63:0]      ca_req_data,
  input  logic             ca_respcyc,
  input  logic [63:0]      ca_resp_data,
  output logic [IW-1:0]    owner,
  output logic             timeout_err
);

  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);

  arb_state_t      state_q, state_d;
  logic [IW-1:0]   owner_ff, owner_d;
  logic [IW-1:0]   last_ff, last_d;
  logic [WD_W-1:0] wd_cnt, wd_d;
  logic [NREQ-1:0] req_mask, pick_mask;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            wd_fire;

  always_comb begin
    req_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mask[i] = (req_cmd[i] != IDLE);
    end
  end

  // On a response the current owner is still requesting, so it is masked out.
  assign pick_mask = (state_q == ARB_BUSY) ? (req_mask & ~(NREQ'(1) << owner_ff)) : req_mask;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (pick_mask),
    .last  (last_ff),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign wd_fire = (TIMEOUT != 0) && (state_q == ARB_BUSY) && !ca_respcyc && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      owner_ff <= LAST_RST;
      last_ff  <= LAST_RST;
      wd_cnt   <= '0;
    end else begin
      state_q  <= state_d;
      owner_ff <= owner_d;
      last_ff  <= last_d;
      wd_cnt   <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_ff;
    last_d  = last_ff;
    wd_d    = wd_cnt;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = ARB_BUSY;
          owner_d = pick_idx;
          last_d  = pick_idx;
          wd_d    = '0;
        end
      end
      ARB_BUSY: begin
        if (ca_respcyc) begin
          wd_d = '0;
          if (pick_valid) begin
            owner_d = pick_idx;
            last_d  = pick_idx;
          end else begin
            state_d = ARB_IDLE;
          end
        end else if (wd_fire) begin
          state_d = ARB_IDLE;
          wd_d    = '0;
        end else begin
          wd_d = wd_cnt + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ca_req_cmd  = IDLE;
    ca_req_addr = '0;
    ca_req_data = '0;
    req_respcyc = '0;
    if (state_q == ARB_BUSY) begin
      ca_req_cmd            = req_cmd[owner_ff];
      ca_req_addr           = req_addr[owner_ff];
      ca_req_data           = req_data[owner_ff];
      req_respcyc[owner_ff] = ca_respcyc;
    end
  end

  assign req_resp_data = ca_resp_data;
  assign owner         = owner_ff;
  assign timeout_err   = wd_fire;

  // An owner must keep its command up until its response arrives.
  owner_holds_cmd: assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ARB_BUSY && !ca_respcyc) |-> (req_cmd[owner_ff] != IDLE));

endmodule
